oled_spi_arbiter: RTL and testbench

OLED_SPI_ARBITER -- requirements
Module: oled_spi_arbiter

---
 rtl/oled_spi_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_oled_spi_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oled_spi_arbiter.sv
// Three-way arbiter in front of a byte-wide SPI master driving an OLED panel.
// Requester 0 owns the bus during panel initialisation; requesters 1 and 2 share it
// round-robin afterwards. An owner may lock the bus across consecutive bytes.
// A per-byte watchdog turns a missing spi_send_done into a timeout_err pulse.
module oled_spi_arbiter #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       init_done,
  input  logic       req0_send,
  input  logic [7:0] req0_data,
  input  logic       req0_dc,
  input  logic       req0_lock,
  output logic       req0_done,
  input  logic       req1_send,
  input  logic [7:0] req1_data,
  input  logic       req1_dc,
  input  logic       req1_lock,
  output logic       req1_done,
  input  logic       req2_send,
  input  logic [7:0] req2_data,
  input  logic       req2_dc,
  input  logic       req2_lock,
  output logic       req2_done,
  output logic       spi_send,
  output logic [7:0] spi_data,
  output logic       spi_dc,
  input  logic       spi_send_done,
  output logic [1:0] grant,
  output logic       busy,
  output logic       timeout_err
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            spi_send_q, spi_send_d;
  logic [7:0]      spi_data_q, spi_data_d;
  logic            spi_dc_q, spi_dc_d;
  logic [1:0]      grant_q, grant_d;
  logic            busy_q, busy_d;
  logic            timeout_q, timeout_d;
  logic [2:0]      done_q, done_d;
  logic            lock_q, lock_d;
  logic [1:0]      lock_owner_q, lock_owner_d;
  logic            prefer2_q, prefer2_d;

  logic [3:0] send_v, lock_raw, lock_elig;
  logic       lock_live, pick_valid, pick_dc;
  logic [1:0] pick;
  logic [7:0] pick_data;

  assign send_v    = {1'b0, req2_send, req1_send, req0_send};
  assign lock_raw  = {1'b0, req2_lock, req1_lock, req0_lock};
  // A lock survives only while its owner still asks for it and is still eligible.
  assign lock_elig = {1'b0, req2_lock & init_done, req1_lock & init_done, req0_lock & ~init_done};
  assign lock_live = lock_q & lock_elig[lock_owner_q];

  // Pick the winner among eligible requesters (lock first, then phase, then round-robin).
  always_comb begin
    pick_valid = 1'b0;
    pick       = 2'd3;
    if (lock_live) begin
      pick_valid = send_v[lock_owner_q];
      pick       = lock_owner_q;
    end else if (!init_done) begin
      pick_valid = req0_send;
      pick       = 2'd0;
    end else if (req1_send && req2_send) begin
      pick_valid = 1'b1;
      pick       = prefer2_q ? 2'd2 : 2'd1;
    end else if (req1_send) begin
      pick_valid = 1'b1;
      pick       = 2'd1;
    end else if (req2_send) begin
      pick_valid = 1'b1;
      pick       = 2'd2;
    end
  end

  // Select the winner's byte and dc flag.
  always_comb begin
    pick_data = req0_data;
    pick_dc   = req0_dc;
    case (pick)
      2'd1: begin
        pick_data = req1_data;
        pick_dc   = req1_dc;
      end
      2'd2: begin
        pick_data = req2_data;
        pick_dc   = req2_dc;
      end
      default: ;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (pick_valid) state_d = StIssue;
      StIssue: state_d = StWait;
      StWait:  if (spi_send_done || (cnt_q == CntLast)) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Next values for the registered outputs, watchdog, lock and round-robin state.
  always_comb begin
    spi_send_d   = 1'b0;
    spi_data_d   = spi_data_q;
    spi_dc_d     = spi_dc_q;
    grant_d      = grant_q;
    done_d       = 3'b000;
    timeout_d    = 1'b0;
    cnt_d        = cnt_q;
    lock_d       = lock_q;
    lock_owner_d = lock_owner_q;
    prefer2_d    = prefer2_q;
    busy_d       = (state_d != StIdle);
    unique case (state_q)
      StIdle: begin
        lock_d = lock_live;
        if (pick_valid) begin
          spi_send_d = 1'b1;
          spi_data_d = pick_data;
          spi_dc_d   = pick_dc;
          grant_d    = pick;
          if (pick == 2'd1) begin
            prefer2_d = 1'b1;
          end else if (pick == 2'd2) begin
            prefer2_d = 1'b0;
          end
        end
      end
      StIssue: cnt_d = '0;
      StWait: begin
        if (spi_send_done) begin
          done_d = {grant_q == 2'd2, grant_q == 2'd1, grant_q == 2'd0};
        end else if (cnt_q == CntLast) begin
          done_d    = {grant_q == 2'd2, grant_q == 2'd1, grant_q == 2'd0};
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        grant_d      = 2'd3;
        lock_owner_d = grant_q;
        // A timed-out byte never hands the bus straight back to its owner.
        lock_d       = ~timeout_q & lock_raw[grant_q];
      end
      default: ;
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      spi_send_q   <= 1'b0;
      spi_data_q   <= 8'h00;
      spi_dc_q     <= 1'b0;
      grant_q      <= 2'd3;
      busy_q       <= 1'b0;
      timeout_q    <= 1'b0;
      done_q       <= 3'b000;
      lock_q       <= 1'b0;
      lock_owner_q <= 2'd0;
      prefer2_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      spi_send_q   <= spi_send_d;
      spi_data_q   <= spi_data_d;
      spi_dc_q     <= spi_dc_d;
      grant_q      <= grant_d;
      busy_q       <= busy_d;
      timeout_q    <= timeout_d;
      done_q       <= done_d;
      lock_q       <= lock_d;
      lock_owner_q <= lock_owner_d;
      prefer2_q    <= prefer2_d;
    end
  end

  assign spi_send    = spi_send_q;
  assign spi_data    = spi_data_q;
  assign spi_dc      = spi_dc_q;
  assign grant       = grant_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_q;
  assign req0_done   = done_q[0];
  assign req1_done   = done_q[1];
  assign req2_done   = done_q[2];

endmodule

// File: tb/tb_oled_spi_arbiter.sv
// Bench for oled_spi_arbiter: directed phases plus a randomized phase, all checked
// against a transaction-level model of the arbitration rules.
module tb_oled_spi_arbiter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       init;
  bit   [2:0] snd, dcv, lck;
  logic [7:0] dat [3];
  logic       sdone;

  logic       req0_done, req1_done, req2_done;
  logic       spi_send, spi_dc, busy, timeout_err;
  logic [7:0] spi_data;
  logic [1:0] grant;
  logic [2:0] dn;

  int total = 0;
  int bad = 0;

  // Model state: who holds a lock (-1 none), round-robin preference, last latched byte.
  int         lock_owner = -1;
  bit         prefer2 = 1'b0;
  logic [7:0] last_data = 8'h00;
  logic       last_dc = 1'b0;

  always #5 clk = ~clk;

  assign dn = {req2_done, req1_done, req0_done};

  oled_spi_arbiter #(.TIMEOUT(16)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .init_done    (init),
    .req0_send    (snd[0]),
    .req0_data    (dat[0]),
    .req0_dc      (dcv[0]),
    .req0_lock    (lck[0]),
    .req0_done    (req0_done),
    .req1_send    (snd[1]),
    .req1_data    (dat[1]),
    .req1_dc      (dcv[1]),
    .req1_lock    (lck[1]),
    .req1_done    (req1_done),
    .req2_send    (snd[2]),
    .req2_data    (dat[2]),
    .req2_dc      (dcv[2]),
    .req2_lock    (lck[2]),
    .req2_done    (req2_done),
    .spi_send     (spi_send),
    .spi_data     (spi_data),
    .spi_dc       (spi_dc),
    .spi_send_done(sdone),
    .grant        (grant),
    .busy         (busy),
    .timeout_err  (timeout_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit elig(input int n);
    return init ? (n != 0) : (n == 0);
  endfunction

  // Winner of the next IDLE sampling edge according to the arbitration rules.
  function automatic int model_pick();
    int w;
    w = -1;
    if (lock_owner >= 0 && !(lck[lock_owner] && elig(lock_owner))) lock_owner = -1;
    if (lock_owner >= 0) w = snd[lock_owner] ? lock_owner : -1;
    else if (!init) w = snd[0] ? 0 : -1;
    else if (snd[1] && snd[2]) w = prefer2 ? 2 : 1;
    else if (snd[1]) w = 1;
    else if (snd[2]) w = 2;
    if (w == 1) prefer2 = 1'b1;
    else if (w == 2) prefer2 = 1'b0;
    return w;
  endfunction

  // Called at a negedge while the DUT is idle; returns at the negedge of the DONE cycle.
  // delay = cycles from spi_send to the spi_send_done pulse; 0 means never answer.
  task automatic run_txn(input int delay, input bit flip_init, output int n, output bit to);
    n  = model_pick();
    to = (delay == 0);
    if (n < 0) begin
      @(negedge clk);
      chk("idle_no_send", spi_send, 0);
      chk("idle_no_grant", grant, 3);
      return;
    end
    last_data = dat[n];
    last_dc   = dcv[n];
    @(negedge clk);
    chk("issue_send", spi_send, 1);
    chk("issue_grant", grant, n);
    chk("issue_data", spi_data, last_data);
    chk("issue_dc", spi_dc, last_dc);
    chk("issue_busy", busy, 1);
    if (flip_init) init = ~init;
    @(negedge clk);
    chk("wait_send_low", spi_send, 0);
    if (to) begin
      repeat (15) @(negedge clk);
    end else begin
      repeat (delay - 1) @(negedge clk);
      sdone = 1'b1;
    end
    chk("wait_no_done", dn, 0);
    chk("wait_no_timeout", timeout_err, 0);
    @(negedge clk);
    sdone = 1'b0;
    chk("done_pulse", dn, 1 << n);
    chk("done_timeout", timeout_err, to);
    chk("done_grant", grant, n);
    chk("done_busy", busy, 1);
  endtask

  // Called at the DONE negedge after the requester has reacted; ends in the IDLE cycle.
  task automatic finish_txn(input int n, input bit to);
    lock_owner = (!to && lck[n]) ? n : -1;
    @(negedge clk);
    chk("idle_grant", grant, 3);
    chk("idle_busy", busy, 0);
    chk("idle_done", dn, 0);
    chk("idle_timeout", timeout_err, 0);
    chk("idle_send", spi_send, 0);
    chk("hold_data", spi_data, last_data);
    chk("hold_dc", spi_dc, last_dc);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    bit to;
    int nb;
    int dly;
    reset_n = 1'b1;
    init    = 1'b0;
    snd     = '0;
    dcv     = '0;
    lck     = '0;
    sdone   = 1'b0;
    for (int i = 0; i < 3; i++) dat[i] = 8'h00;

    // Reset values.
    #3 reset_n = 1'b0;
    #1;
    chk("rst_grant", grant, 3);
    chk("rst_send", spi_send, 0);
    chk("rst_data", spi_data, 8'h00);
    chk("rst_dc", spi_dc, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout", timeout_err, 0);
    chk("rst_done", dn, 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Init phase: only req0 eligible.
    snd    = 3'b011;
    dat[0] = 8'hAE;
    dcv[0] = 1'b0;
    dat[1] = 8'h55;
    dcv[1] = 1'b1;
    run_txn(3, 1'b0, n, to);
    snd[0] = 1'b0;
    finish_txn(n, to);

    // Round robin between req1 and req2.
    init   = 1'b1;
    snd    = 3'b110;
    dat[2] = 8'($urandom);
    dcv[2] = 1'($urandom);
    repeat (4) begin
      run_txn(5, 1'b0, n, to);
      dat[n] = 8'($urandom);
      dcv[n] = 1'($urandom);
      finish_txn(n, to);
    end

    // Lock held by req1 across three bytes.
    nb     = 0;
    lck[1] = 1'b1;
    repeat (4) begin
      run_txn(int'($urandom_range(1, 6)), 1'b0, n, to);
      dat[n] = 8'($urandom);
      if (n == 1) begin
        nb++;
        lck[1] = (nb < 3);
      end
      finish_txn(n, to);
    end
    lck = '0;

    // Timeout clears the lock, so round robin moves on to req2.
    lck[1] = 1'b1;
    run_txn(0, 1'b0, n, to);
    finish_txn(n, to);
    run_txn(2, 1'b0, n, to);
    snd[2] = 1'b0;
    finish_txn(n, to);
    lck = '0;

    // Reset during WAIT: no done pulse, round robin restarts favouring req1.
    snd = 3'b010;
    n   = model_pick();
    @(negedge clk);
    chk("rstw_send", spi_send, 1);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("rstw_grant", grant, 3);
    chk("rstw_busy", busy, 0);
    chk("rstw_send0", spi_send, 0);
    chk("rstw_data", spi_data, 8'h00);
    chk("rstw_done", dn, 0);
    lock_owner = -1;
    prefer2    = 1'b0;
    last_data  = 8'h00;
    last_dc    = 1'b0;
    @(negedge clk);
    chk("rstw_done_later", dn, 0);
    snd     = 3'b110;
    dat[1]  = 8'($urandom);
    dat[2]  = 8'($urandom);
    reset_n = 1'b1;
    run_txn(4, 1'b0, n, to);
    snd = '0;
    finish_txn(n, to);

    // Stray spi_send_done while idle.
    sdone = 1'b1;
    @(negedge clk);
    sdone = 1'b0;
    chk("stray_busy", busy, 0);
    chk("stray_grant", grant, 3);
    chk("stray_done", dn, 0);
    chk("stray_send", spi_send, 0);
    @(negedge clk);
    chk("stray_busy2", busy, 0);
    chk("stray_done2", dn, 0);

    // init_done changes: lock dropped on eligibility loss, mid-transfer change tolerated.
    init   = 1'b0;
    snd    = 3'b001;
    dat[0] = 8'($urandom);
    lck[0] = 1'b1;
    run_txn(2, 1'b0, n, to);
    dat[0] = 8'($urandom);
    finish_txn(n, to);
    init   = 1'b1;
    snd[1] = 1'b1;
    dat[1] = 8'($urandom);
    run_txn(3, 1'b1, n, to);
    snd[1] = 1'b0;
    lck[0] = 1'b0;
    finish_txn(n, to);
    run_txn(2, 1'b0, n, to);
    snd[0] = 1'b0;
    finish_txn(n, to);

    // Randomized traffic after initialisation, with stray req0 requests and timeouts.
    init = 1'b1;
    lck  = '0;
    repeat (30) begin
      if (!snd[1] && !snd[2]) begin
        nb      = int'($urandom_range(1, 2));
        snd[nb] = 1'b1;
        dat[nb] = 8'($urandom);
        dcv[nb] = 1'($urandom);
      end
      dly = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 8));
      run_txn(dly, 1'b0, n, to);
      if (n >= 0) begin
        snd[n] = 1'($urandom);
        dat[n] = 8'($urandom);
        dcv[n] = 1'($urandom);
        lck[n] = snd[n] & ($urandom_range(0, 2) == 0);
        snd[0] = 1'($urandom);
        finish_txn(n, to);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
